counter_ctrl: RTL and testbench

Sequencing controller for the 4-bit counting datapath. It owns the count register and adds run/pause/clear command handling, a clock prescaler, a programmable terminal value and a one-shot or auto-reload policy. It reports progress through `done` and `busy`. It sits between the front-panel/command logic and the count display, and replaces free-running counting wherever the count must be started, stopped and bounded.

---
 rtl/counter_ctrl.sv | 143 ++++++++++++++
 tb/tb_counter_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_ctrl.sv
// counter_ctrl: sequencing controller for the counting datapath.
// Owns the count register and handles run/pause/clear commands, a clock
// prescaler (DIV ck cycles per count step), a programmable terminal value
// and a one-shot or auto-reload policy.
//
// Parameters:
//   WIDTH      count and limit width
//   DIV        ck cycles per count step (1..256)
// Ports:
//   ck         clock, rising edge
//   res        asynchronous active-high reset
//   start      begin or resume counting
//   pause      freeze count and prescaler
//   clear      abort and return to zero/idle
//   limit      terminal count, captured on start from IDLE or DONE
//   autoreload reload policy, captured together with limit
//   q          current count (registered)
//   busy       high in RUN or HOLD (registered)
//   done       one-cycle pulse when the terminal count is reached
//   state      IDLE=00, RUN=01, HOLD=10, DONE=11
module counter_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV   = 4
) (
  input  logic             ck,
  input  logic             res,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic [WIDTH-1:0] limit,
  input  logic             autoreload,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  // A one-bit prescaler is kept for DIV=1 so the compare is always legal;
  // with PMAX=0 every RUN cycle ticks.
  localparam int unsigned   PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t           st;
  logic [PW-1:0]    presc;
  logic [WIDTH-1:0] lim_r;
  logic             ar_r;

  assign state = st;

  // Command priority is clear > pause > start; lower-priority commands are
  // only examined when no higher one is asserted.
  always_ff @(posedge ck or posedge res) begin
    if (res) begin
      st    <= IDLE;
      q     <= '0;
      presc <= '0;
      lim_r <= '0;
      ar_r  <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: begin
          q <= '0;
          if (!clear && !pause && start) begin
            st    <= RUN;
            busy  <= 1'b1;
            lim_r <= limit;
            ar_r  <= autoreload;
            presc <= '0;
          end
        end

        RUN: begin
          if (clear) begin
            st    <= IDLE;
            busy  <= 1'b0;
            q     <= '0;
            presc <= '0;
          end else if (pause) begin
            st <= HOLD;
          end else if (presc == PMAX) begin
            presc <= '0;
            // Terminal compare precedes the increment, so q never passes lim_r.
            if (q == lim_r) begin
              done <= 1'b1;
              if (ar_r) begin
                q <= '0;
              end else begin
                st   <= DONE;
                busy <= 1'b0;
              end
            end else begin
              q <= q + WIDTH'(1);
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end

        HOLD: begin
          if (clear) begin
            st    <= IDLE;
            busy  <= 1'b0;
            q     <= '0;
            presc <= '0;
          end else if (!pause && start) begin
            // Prescaler keeps its frozen phase on resume.
            st <= RUN;
          end
        end

        DONE: begin
          q <= lim_r;
          if (clear) begin
            st    <= IDLE;
            busy  <= 1'b0;
            q     <= '0;
            presc <= '0;
          end else if (!pause && start) begin
            st    <= RUN;
            busy  <= 1'b1;
            q     <= '0;
            presc <= '0;
            lim_r <= limit;
            ar_r  <= autoreload;
          end
        end

        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Testbench for counter_ctrl (WIDTH=4, DIV=2). A reference model tracks
// the number of counting cycles spent in RUN since the last start and
// derives q/done/state from that with plain arithmetic; a compare process
// checks every cycle, and directed checks pin key points with literals.
module tb_counter_ctrl;

  localparam int W = 4;
  localparam int D = 2;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_HOLD = 2;
  localparam int S_DONE = 3;

  logic         ck = 1'b0;
  logic         res;
  logic         start = 1'b0;
  logic         pause = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] limit = '0;
  logic         autoreload = 1'b0;
  logic [W-1:0] q;
  logic         busy;
  logic         done;
  logic [1:0]   state;

  int tests_run = 0;
  int fails     = 0;
  bit chk_en    = 1'b0;

  counter_ctrl #(.WIDTH(W), .DIV(D)) dut (
    .ck(ck), .res(res), .start(start), .pause(pause), .clear(clear),
    .limit(limit), .autoreload(autoreload),
    .q(q), .busy(busy), .done(done), .state(state)
  );

  always #5 ck = ~ck;

  // Reference model: rc = counting cycles consumed since the accepted start.
  int m_st, rc, m_lim, m_done;
  bit m_ar;

  always @(posedge ck or posedge res) begin
    if (res) begin
      m_st = S_IDLE; rc = 0; m_lim = 0; m_ar = 1'b0; m_done = 0;
    end else begin
      m_done = 0;
      case (m_st)
        S_IDLE: if (!clear && !pause && start) begin
          m_st = S_RUN; rc = 0; m_lim = int'(limit); m_ar = autoreload;
        end
        S_RUN: begin
          if (clear) m_st = S_IDLE;
          else if (pause) m_st = S_HOLD;
          else begin
            rc = rc + 1;
            if (m_ar) begin
              if (rc % ((m_lim + 1) * D) == 0) m_done = 1;
            end else if (rc == (m_lim + 1) * D) begin
              m_done = 1; m_st = S_DONE;
            end
          end
        end
        S_HOLD: begin
          if (clear) m_st = S_IDLE;
          else if (!pause && start) m_st = S_RUN;
        end
        default: begin
          if (clear) m_st = S_IDLE;
          else if (!pause && start) begin
            m_st = S_RUN; rc = 0; m_lim = int'(limit); m_ar = autoreload;
          end
        end
      endcase
    end
  end

  function automatic int exp_q();
    case (m_st)
      S_IDLE:  return 0;
      S_DONE:  return m_lim;
      default: return m_ar ? (rc / D) % (m_lim + 1) : rc / D;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge ck) begin
    if (chk_en) begin
      chk("model_q",     32'(q),     32'(exp_q()));
      chk("model_state", 32'(state), 32'(m_st));
      chk("model_busy",  32'(busy),  32'((m_st == S_RUN || m_st == S_HOLD) ? 1 : 0));
      chk("model_done",  32'(done),  32'(m_done));
    end
  end

  // Advance to just after the next rising edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge ck);
      #1;
    end
  endtask

  task automatic cmd_start(input logic [W-1:0] lim, input logic ar);
    limit = lim; autoreload = ar; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    res = 1'b1;
    step();
    res = 1'b0;
    chk_en = 1'b1;

    // Reset and idle
    chk("rst_q", 32'(q), 0);
    chk("rst_state", 32'(state), 0);
    step(5);
    chk("idle_busy", 32'(busy), 0);
    pause = 1'b1; step(); pause = 1'b0;
    chk("idle_pause_state", 32'(state), 0);

    // One-shot, limit 3
    cmd_start(4'd3, 1'b0);
    chk("os_run", 32'(state), 1);
    step(2); chk("os_q1", 32'(q), 1);
    step(2); chk("os_q2", 32'(q), 2);
    step(2); chk("os_q3", 32'(q), 3);
    step(1); chk("os_nodone_k7", 32'(done), 0);
    step(1); chk("os_done", 32'(done), 1);
    chk("os_state_done", 32'(state), 3);
    step(1); chk("os_done_low", 32'(done), 0);
    chk("os_hold_q", 32'(q), 3);

    // Auto-reload, limit 2 (restart from DONE)
    cmd_start(4'd2, 1'b1);
    chk("ar_q0", 32'(q), 0);
    step(4); chk("ar_q2", 32'(q), 2);
    step(2); chk("ar_done1", 32'(done), 1);
    chk("ar_wrap_q", 32'(q), 0);
    chk("ar_state", 32'(state), 1);
    step(6); chk("ar_done2", 32'(done), 1);
    step(3);

    // Pause/resume, limit 5
    clear = 1'b1; step(); clear = 1'b0;
    cmd_start(4'd5, 1'b0);
    step(5);
    chk("pr_q_before", 32'(q), 2);
    pause = 1'b1; step(); pause = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("pr_hold_q", 32'(q), 2);
      chk("pr_hold_state", 32'(state), 2);
    end
    start = 1'b1; step(); start = 1'b0;
    chk("pr_resumed", 32'(state), 1);
    step(1); chk("pr_phase_q", 32'(q), 3);
    step(5); chk("pr_nodone", 32'(done), 0);
    step(1); chk("pr_done", 32'(done), 1);

    // Triple command in RUN
    cmd_start(4'd9, 1'b0);
    step(3);
    clear = 1'b1; pause = 1'b1; start = 1'b1; step();
    clear = 1'b0; pause = 1'b0; start = 1'b0;
    chk("tri_state", 32'(state), 0);
    chk("tri_q", 32'(q), 0);

    // Clear coincident with terminal tick suppresses done
    cmd_start(4'd0, 1'b0);
    step(1);
    clear = 1'b1; step(); clear = 1'b0;
    chk("clr_tick_done", 32'(done), 0);
    chk("clr_tick_state", 32'(state), 0);

    // limit 0
    cmd_start(4'd0, 1'b0);
    step(1); chk("l0_nodone", 32'(done), 0);
    step(1); chk("l0_done", 32'(done), 1);
    chk("l0_q", 32'(q), 0);

    // limit 15, full range
    cmd_start(4'd15, 1'b0);
    step(30); chk("l15_q", 32'(q), 15);
    step(1);  chk("l15_nodone", 32'(done), 0);
    step(1);  chk("l15_done", 32'(done), 1);
    chk("l15_state", 32'(state), 3);

    // Asynchronous reset mid-run
    cmd_start(4'd9, 1'b0);
    step(10);
    chk("ar_pre_q", 32'(q), 5);
    #2 res = 1'b1;
    #1;
    chk("async_q", 32'(q), 0);
    chk("async_state", 32'(state), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_done", 32'(done), 0);
    step();
    res = 1'b0;
    step();
    cmd_start(4'd1, 1'b0);
    step(2); chk("post_rst_q1", 32'(q), 1);
    step(2); chk("post_rst_done", 32'(done), 1);
    step(2);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
